// File: rtl/ring_slot_scheduler_pkg.sv
// Shared types and defaults for the ring slot scheduler.
// State encoding, default sizing and the completed-grant counter width.
package ring_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam int N_DEF        = 8;
    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W        = 16;

endpackage

// File: rtl/ring_slot_scheduler_if.sv
// Requester-facing bundle of the ring slot scheduler.
// master = requester side, slave = scheduler side.
interface ring_slot_scheduler_if
    import ring_sched_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);
    logic             enable;
    logic [N-1:0]     req;
    logic [N-1:0]     done;
    logic [N-1:0]     grant;
    logic [IW-1:0]    slot_idx;
    logic             busy;
    logic             timeout;
    logic [CNT_W-1:0] grant_count;

    modport master (
        output enable, req, done,
        input  grant, slot_idx, busy, timeout, grant_count
    );

    modport slave (
        input  enable, req, done,
        output grant, slot_idx, busy, timeout, grant_count
    );
endinterface

// File: rtl/ring_slot_scheduler_rr_pick.sv
// Round-robin picker: first set req bit at or above the one-hot token, with wrap.
// Latency: combinational. Backpressure: none.
// Flow control: none; the pick is held stable only while req and token are stable.
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  token,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx
);
    int   tpos;
    int   j;
    logic found;

    always_comb begin
        tpos     = 0;
        j        = 0;
        found    = 1'b0;
        pick     = '0;
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (token[i]) tpos = i;
        end
        // Walk upward from the token slot, wrapping past N-1 back to 0.
        for (int i = 0; i < N; i++) begin
            j = tpos + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/ring_slot_scheduler.sv
// Round-robin ring slot scheduler with hold limit and one idle GAP cycle per release.
// Latency: grant one edge after req seen in IDLE; next grant at release + 2 edges.
// Backpressure: enable gates new grants only; a running grant ends on done, req drop or hold limit.
module ring_slot_scheduler
    import ring_sched_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 init,
    ring_slot_scheduler_if.slave sif
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    sched_state_t     state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [N-1:0]     token_q, token_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [N-1:0]     pick;
    logic [IW-1:0]    pick_idx;
    logic             done_hit, req_hit, at_limit;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req      (sif.req),
        .token    (token_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign done_hit = sif.done[idx_q];
    assign req_hit  = sif.req[idx_q];
    assign at_limit = (hold_q == HW'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        token_d   = token_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sif.enable && (|sif.req)) begin
                    state_d = GRANT;
                    grant_d = pick;
                    idx_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (done_hit || !req_hit || at_limit) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    token_d   = {grant_q[N-2:0], grant_q[N-1]};
                    cnt_d     = cnt_q + CNT_W'(1);
                    // A release already explained by done or a req drop is not a timeout.
                    timeout_d = at_limit && !done_hit && req_hit;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            token_q   <= N'(1);
            idx_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            token_q   <= token_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign sif.grant       = grant_q;
    assign sif.slot_idx    = idx_q;
    assign sif.busy        = |grant_q;
    assign sif.timeout     = timeout_q;
    assign sif.grant_count = cnt_q;
endmodule

// File: tb/tb_ring_slot_scheduler.sv
// Directed bench for ring_slot_scheduler (N=8, MAX_HOLD=16); expected values are hand-derived.
module tb_ring_slot_scheduler;
    import ring_sched_pkg::*;

    logic clk;
    logic init;
    int   n_cmp;
    int   n_bad;
    logic [15:0] exp_cnt;

    ring_slot_scheduler_if #(.N(8)) sif ();

    ring_slot_scheduler #(.N(8), .MAX_HOLD(16)) dut (
        .clk  (clk),
        .init (init),
        .sif  (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        init = 1'b1; sif.enable = 1'b1; sif.req = '0; sif.done = '0;
        tick(); tick();
        init = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL reset_grant cyc %0d: got %h want 00", i, sif.grant); end
            n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, sif.busy); end
            n_cmp++; if (sif.grant_count !== 16'd0) begin n_bad++; $display("FAIL reset_count cyc %0d: got %0d want 0", i, sif.grant_count); end
            n_cmp++; if (sif.slot_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx cyc %0d: got %0d want 0", i, sif.slot_idx); end
            n_cmp++; if (sif.timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout cyc %0d: got %b want 0", i, sif.timeout); end
            tick();
        end
        exp_cnt = 16'd0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g;
        sif.req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            n_cmp++; if (sif.grant !== exp_g) begin n_bad++; $display("FAIL rr_grant k=%0d: got %h want %h", k, sif.grant, exp_g); end
            n_cmp++; if (sif.slot_idx !== 3'(k % 8)) begin n_bad++; $display("FAIL rr_idx k=%0d: got %0d want %0d", k, sif.slot_idx, k % 8); end
            tick();
            n_cmp++; if (sif.grant !== exp_g) begin n_bad++; $display("FAIL rr_hold k=%0d: got %h want %h", k, sif.grant, exp_g); end
            sif.done = exp_g;
            tick();
            sif.done = '0;
            exp_cnt = exp_cnt + 16'd1;
            n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL rr_gap k=%0d: got %h want 00", k, sif.grant); end
            n_cmp++; if (sif.grant_count !== exp_cnt) begin n_bad++; $display("FAIL rr_count k=%0d: got %0d want %0d", k, sif.grant_count, exp_cnt); end
            n_cmp++; if (sif.timeout !== 1'b0) begin n_bad++; $display("FAIL rr_timeout k=%0d: got %b want 0", k, sif.timeout); end
            if (k == 8) sif.req = '0;
            tick();
            n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL rr_idle k=%0d: got %h want 00", k, sif.grant); end
            tick();
        end
        n_cmp++; if (sif.grant_count !== 16'd9) begin n_bad++; $display("FAIL rr_total: got %0d want 9", sif.grant_count); end
        n_cmp++; if (sif.slot_idx !== 3'd0) begin n_bad++; $display("FAIL rr_idx_idle: got %0d want 0", sif.slot_idx); end
        n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL rr_busy_idle: got %b want 0", sif.busy); end
    endtask

    task automatic test_timeout();
        sif.req = 8'h04;
        tick();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (sif.grant !== 8'h04) begin n_bad++; $display("FAIL to_grant cyc %0d: got %h want 04", i, sif.grant); end
            n_cmp++; if (sif.timeout !== 1'b0) begin n_bad++; $display("FAIL to_early cyc %0d: got %b want 0", i, sif.timeout); end
            tick();
        end
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL to_release: got %h want 00", sif.grant); end
        n_cmp++; if (sif.timeout !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", sif.timeout); end
        n_cmp++; if (sif.grant_count !== exp_cnt) begin n_bad++; $display("FAIL to_count: got %0d want %0d", sif.grant_count, exp_cnt); end
        tick();
        n_cmp++; if (sif.timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse_len: got %b want 0", sif.timeout); end
        n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL to_idle: got %h want 00", sif.grant); end
        tick();
        n_cmp++; if (sif.grant !== 8'h04) begin n_bad++; $display("FAIL to_regrant: got %h want 04", sif.grant); end
        sif.req = '0;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL to_reqdrop: got %h want 00", sif.grant); end
        n_cmp++; if (sif.timeout !== 1'b0) begin n_bad++; $display("FAIL to_reqdrop_to: got %b want 0", sif.timeout); end
        n_cmp++; if (sif.grant_count !== exp_cnt) begin n_bad++; $display("FAIL to_reqdrop_cnt: got %0d want %0d", sif.grant_count, exp_cnt); end
        tick();
    endtask

    task automatic test_simultaneous();
        sif.req = 8'h08;
        tick();
        for (int i = 1; i <= 15; i++) begin
            sif.done = (i == 6) ? 8'hF7 : 8'h00;
            tick();
        end
        n_cmp++; if (sif.grant !== 8'h08) begin n_bad++; $display("FAIL sim_foreign_done: got %h want 08", sif.grant); end
        sif.done = 8'h08;
        tick();
        sif.done = '0;
        sif.req  = '0;
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL sim_release: got %h want 00", sif.grant); end
        n_cmp++; if (sif.timeout !== 1'b0) begin n_bad++; $display("FAIL sim_timeout: got %b want 0", sif.timeout); end
        n_cmp++; if (sif.grant_count !== exp_cnt) begin n_bad++; $display("FAIL sim_count: got %0d want %0d", sif.grant_count, exp_cnt); end
        tick();
    endtask

    task automatic test_wrap();
        sif.req = 8'h40;
        tick();
        n_cmp++; if (sif.grant !== 8'h40) begin n_bad++; $display("FAIL wrap_prep: got %h want 40", sif.grant); end
        sif.req = '0;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        sif.req = 8'h81;
        tick(); tick();
        n_cmp++; if (sif.grant !== 8'h80) begin n_bad++; $display("FAIL wrap_first: got %h want 80", sif.grant); end
        n_cmp++; if (sif.slot_idx !== 3'd7) begin n_bad++; $display("FAIL wrap_idx7: got %0d want 7", sif.slot_idx); end
        sif.done = 8'h80;
        tick();
        sif.done = '0;
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (sif.grant_count !== exp_cnt) begin n_bad++; $display("FAIL wrap_count: got %0d want %0d", sif.grant_count, exp_cnt); end
        tick(); tick();
        n_cmp++; if (sif.grant !== 8'h01) begin n_bad++; $display("FAIL wrap_second: got %h want 01", sif.grant); end
        sif.done = 8'h01;
        tick();
        sif.done = '0;
        sif.req  = '0;
        exp_cnt = exp_cnt + 16'd1;
        tick();
    endtask

    task automatic test_enable_and_init();
        sif.req = 8'h22;
        tick();
        n_cmp++; if (sif.grant !== 8'h02) begin n_bad++; $display("FAIL en_grant: got %h want 02", sif.grant); end
        sif.enable = 1'b0;
        tick();
        n_cmp++; if (sif.grant !== 8'h02) begin n_bad++; $display("FAIL en_hold: got %h want 02", sif.grant); end
        sif.done = 8'h02;
        tick();
        sif.done = '0;
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (sif.grant_count !== exp_cnt) begin n_bad++; $display("FAIL en_count: got %0d want %0d", sif.grant_count, exp_cnt); end
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL en_blocked cyc %0d: got %h want 00", i, sif.grant); end
        end
        sif.enable = 1'b1;
        tick();
        n_cmp++; if (sif.grant !== 8'h20) begin n_bad++; $display("FAIL en_resume: got %h want 20", sif.grant); end
        n_cmp++; if (sif.slot_idx !== 3'd5) begin n_bad++; $display("FAIL en_idx5: got %0d want 5", sif.slot_idx); end
        init = 1'b1;
        tick();
        init = 1'b0;
        n_cmp++; if (sif.grant !== 8'h00) begin n_bad++; $display("FAIL init_grant: got %h want 00", sif.grant); end
        n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL init_busy: got %b want 0", sif.busy); end
        n_cmp++; if (sif.grant_count !== 16'd0) begin n_bad++; $display("FAIL init_count: got %0d want 0", sif.grant_count); end
        n_cmp++; if (sif.slot_idx !== 3'd0) begin n_bad++; $display("FAIL init_idx: got %0d want 0", sif.slot_idx); end
        sif.req = 8'hFF;
        tick();
        n_cmp++; if (sif.grant !== 8'h01) begin n_bad++; $display("FAIL init_token: got %h want 01", sif.grant); end
        sif.done = 8'h01;
        tick();
        sif.done = '0;
        sif.req  = '0;
        n_cmp++; if (sif.grant_count !== 16'd1) begin n_bad++; $display("FAIL init_uncounted: got %0d want 1", sif.grant_count); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_cnt = 16'd0;
        init = 1'b1;
        sif.enable = 1'b0;
        sif.req = '0;
        sif.done = '0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_wrap();
        test_enable_and_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
